decoder_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one registered SEL_WIDTH-to-2^SEL_WIDTH one-hot decoder among NUM_REQ requesters.
- Each requester submits select-code beats with a valid/ready handshake. The decoded one-hot word leaves through a single-entry output register with a valid/ready handshake.
- Multi-beat bursts (last flag) keep ownership of the decoder. An idle-owner timeout releases a stalled burst.
- Sits between the request masters and the decoder_out interface.

---
 rtl/decoder_share_pkg.sv | 45 ++++
 rtl/decoder_share_arbiter_if.sv | 30 +++
 rtl/decoder_share_rr_pick.sv | 31 +++
 rtl/decoder_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_decoder_share_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_share_pkg.sv
// Shared types and helpers for the round-robin decoder share arbiter.
// rr_pick and onehot_decode work on max-width vectors; callers zero-extend.
package decoder_share_pkg;

   typedef enum logic {ARB, LOCKED} arb_state_e;

   localparam int MAX_REQ = 16;
   localparam int MAX_SEL = 8;
   localparam int MAX_OUT = 1 << MAX_SEL;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;

   function automatic pick_t rr_pick(
      input logic [MAX_REQ-1:0] valid,
      input logic [3:0]         ptr,
      input int                 n
   );
      pick_t res;
      int    j;
      res = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= n) j = j - n;
         if (!res.found && k < n && valid[j[3:0]]) begin
            res.found = 1'b1;
            res.idx   = j[3:0];
         end
      end
      return res;
   endfunction

   function automatic logic [MAX_OUT-1:0] onehot_decode(
      input logic [MAX_SEL-1:0] sel,
      input logic               en
   );
      logic [MAX_OUT-1:0] v;
      v = '0;
      if (en) v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_share_arbiter_if.sv
// Requester and decoded-output handshake bundle of the decoder share arbiter.
interface decoder_share_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int SEL_WIDTH = 3
);
   localparam int OUT_WIDTH = 1 << SEL_WIDTH;
   localparam int ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*SEL_WIDTH-1:0] req_sel;
   logic [NUM_REQ-1:0]           req_en;
   logic [NUM_REQ-1:0]           req_last;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         out_valid;
   logic                         out_ready;
   logic [OUT_WIDTH-1:0]         out_onehot;
   logic [ID_WIDTH-1:0]          out_id;
   logic                         out_last;

   modport master (
      output req_valid, req_sel, req_en, req_last, out_ready,
      input  req_ready, out_valid, out_onehot, out_id, out_last
   );

   modport slave (
      input  req_valid, req_sel, req_en, req_last, out_ready,
      output req_ready, out_valid, out_onehot, out_id, out_last
   );

endinterface

// File: rtl/decoder_share_rr_pick.sv
// Combinational round-robin picker: first valid index at or after i_ptr.
module decoder_share_rr_pick
   import decoder_share_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  i_valid,
   input  logic [ID_WIDTH-1:0] i_ptr,
   output logic                o_found,
   output logic [ID_WIDTH-1:0] o_idx
);

   logic [MAX_REQ-1:0] w_valid;
   logic [3:0]         w_ptr;
   pick_t              w_res;
   logic               w_unused;

   always_comb begin
      w_valid                = '0;
      w_valid[NUM_REQ-1:0]   = i_valid;
      w_ptr                  = '0;
      w_ptr[ID_WIDTH-1:0]    = i_ptr;
      w_res = rr_pick(w_valid, w_ptr, NUM_REQ);
   end

   assign o_found  = w_res.found;
   assign o_idx    = w_res.idx[ID_WIDTH-1:0];
   assign w_unused = ^w_res.idx;

endmodule

// File: rtl/decoder_share_arbiter.sv
// Round-robin arbiter sharing one registered one-hot decoder among requesters,
// with burst locking and an idle-owner timeout.
module decoder_share_arbiter
   import decoder_share_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int SEL_WIDTH    = 3,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   decoder_share_arbiter_if.slave  bus,
   output logic                    busy,
   output logic                    lock_timeout
);

   localparam int OUT_WIDTH = 1 << SEL_WIDTH;
   localparam int ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_WIDTH =
      (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'(LOCK_TIMEOUT - 1);
   localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(NUM_REQ - 1);

   function automatic logic [ID_WIDTH-1:0] inc_id(
      input logic [ID_WIDTH-1:0] id
   );
      return (id == ID_LAST) ? '0 : id + 1'b1;
   endfunction

   arb_state_e           r_state, w_state_nxt;
   logic [ID_WIDTH-1:0]  r_rr_ptr, w_rr_ptr_nxt;
   logic [ID_WIDTH-1:0]  r_owner, w_owner_nxt;
   logic [CNT_WIDTH-1:0] r_idle_cnt, w_idle_nxt;
   logic                 r_tout, w_tout_nxt;
   logic                 r_out_valid;
   logic [OUT_WIDTH-1:0] r_onehot;
   logic [ID_WIDTH-1:0]  r_id;
   logic                 r_last;

   logic                 w_found;
   logic [ID_WIDTH-1:0]  w_pick;
   logic                 w_slot_free;
   logic [ID_WIDTH-1:0]  w_gnt_id;
   logic                 w_gnt_ok;
   logic [NUM_REQ-1:0]   w_ready;
   logic                 w_acc;
   logic                 w_acc_last;
   logic                 w_en;
   logic [SEL_WIDTH-1:0] w_sel;
   logic [MAX_SEL-1:0]   w_sel_ext;
   logic [MAX_OUT-1:0]   w_dec;
   logic                 w_unused;

   decoder_share_rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .i_valid (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_slot_free = !r_out_valid || bus.out_ready;

   // A locked owner is offered the slot whether or not it is valid.
   always_comb begin
      w_gnt_id = (r_state == LOCKED) ? r_owner : w_pick;
      w_gnt_ok = (r_state == LOCKED) || w_found;
      w_ready  = '0;
      if (rst_n && w_gnt_ok && w_slot_free)
         w_ready[w_gnt_id] = 1'b1;
   end

   assign w_acc      = |(bus.req_valid & w_ready);
   assign w_acc_last = bus.req_last[w_gnt_id];
   assign w_en       = bus.req_en[w_gnt_id];
   assign w_sel      = bus.req_sel[w_gnt_id*SEL_WIDTH +: SEL_WIDTH];

   always_comb begin
      w_sel_ext                = '0;
      w_sel_ext[SEL_WIDTH-1:0] = w_sel;
      w_dec = onehot_decode(w_sel_ext, w_en);
   end

   assign w_unused = ^w_dec;

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_owner_nxt  = r_owner;
      w_idle_nxt   = r_idle_cnt;
      w_tout_nxt   = 1'b0;
      unique case (r_state)
         ARB: begin
            if (w_acc) begin
               if (w_acc_last) begin
                  w_rr_ptr_nxt = inc_id(w_gnt_id);
               end else begin
                  w_state_nxt = LOCKED;
                  w_owner_nxt = w_gnt_id;
                  w_idle_nxt  = '0;
               end
            end
         end
         LOCKED: begin
            if (w_acc) begin
               if (w_acc_last) begin
                  w_state_nxt  = ARB;
                  w_rr_ptr_nxt = inc_id(r_owner);
               end else begin
                  w_idle_nxt = '0;
               end
            end else if (!bus.req_valid[r_owner]) begin
               if (r_idle_cnt == CNT_LAST) begin
                  w_state_nxt  = ARB;
                  w_rr_ptr_nxt = inc_id(r_owner);
                  w_tout_nxt   = 1'b1;
               end else begin
                  w_idle_nxt = r_idle_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ARB;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_idle_cnt <= '0;
         r_tout     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_owner    <= w_owner_nxt;
         r_idle_cnt <= w_idle_nxt;
         r_tout     <= w_tout_nxt;
      end
   end

   // An accept overwrites a word being drained in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_onehot    <= '0;
         r_id        <= '0;
         r_last      <= 1'b0;
      end else if (w_acc) begin
         r_out_valid <= 1'b1;
         r_onehot    <= w_dec[OUT_WIDTH-1:0];
         r_id        <= w_gnt_id;
         r_last      <= w_acc_last;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_onehot = r_onehot;
   assign bus.out_id     = r_id;
   assign bus.out_last   = r_last;
   assign busy           = (r_state == LOCKED);
   assign lock_timeout   = r_tout;

endmodule

// File: tb/tb_decoder_share_arbiter.sv
// Directed scoreboard bench for decoder_share_arbiter (4 req, 3-bit sel, timeout 4).
module tb_decoder_share_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic lock_timeout;

   always #5 clk = ~clk;

   decoder_share_arbiter_if #(.NUM_REQ(4), .SEL_WIDTH(3)) bus ();

   decoder_share_arbiter #(
      .NUM_REQ      (4),
      .SEL_WIDTH    (3),
      .LOCK_TIMEOUT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .busy         (busy),
      .lock_timeout (lock_timeout)
   );

   typedef struct packed {
      logic [7:0] oh;
      logic [1:0] id;
      logic       last;
   } word_t;

   word_t exp_q[$];
   word_t mon_w;
   int    total = 0;
   int    bad   = 0;

   logic [7:0] oh_tab [4] = '{8'h02, 8'h00, 8'h20, 8'h80};
   int         g_seq  [6] = '{3, 0, 1, 2, 3, 0};

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic drv(input int i, input logic v,
                      input logic [2:0] s, input logic e,
                      input logic l);
      bus.req_valid[i]      = v;
      bus.req_sel[i*3 +: 3] = s;
      bus.req_en[i]         = e;
      bus.req_last[i]       = l;
   endtask

   task automatic push(input logic [7:0] oh, input logic [1:0] id,
                       input logic last);
      exp_q.push_back('{oh: oh, id: id, last: last});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL word: unexpected oh=%h id=%0d last=%0d",
                     bus.out_onehot, bus.out_id, bus.out_last);
         end else begin
            mon_w = exp_q.pop_front();
            if ({bus.out_onehot, bus.out_id, bus.out_last} !== mon_w) begin
               bad++;
               $display("FAIL word: got oh=%h id=%0d last=%0d want oh=%h id=%0d last=%0d",
                        bus.out_onehot, bus.out_id, bus.out_last,
                        mon_w.oh, mon_w.id, mon_w.last);
            end
         end
      end
   end

   initial begin
      bus.req_valid = '0;
      bus.req_sel   = '0;
      bus.req_en    = '0;
      bus.req_last  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",  32'(bus.out_valid), 0);
      chk("rst_onehot", 32'(bus.out_onehot), 0);
      chk("rst_id",     32'(bus.out_id), 0);
      chk("rst_ready",  32'(bus.req_ready), 0);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_tout",   32'(lock_timeout), 0);
      rst_n = 1'b1;
      cyc();

      // single beat from req 2
      drv(2, 1, 5, 1, 1);
      push(8'h20, 2, 1);
      settle();
      chk("t1_ready", 32'(bus.req_ready), 32'h4);
      cyc();
      drv(2, 0, 0, 0, 0);
      settle();
      chk("t1_latency", 32'(bus.out_valid), 1);
      chk("t1_onehot",  32'(bus.out_onehot), 32'h20);
      cyc();

      // all valid, rotating grants starting at 3
      for (int i = 0; i < 4; i++)
         drv(i, 1, 3'(2*i+1), (i != 1), 1);
      for (int k = 0; k < 6; k++) begin
         settle();
         chk("t2_grant", 32'(bus.req_ready), 32'(1 << g_seq[k]));
         if (k > 0) chk("t2_nobubble", 32'(bus.out_valid), 1);
         push(oh_tab[g_seq[k]], 2'(g_seq[k]), 1);
         cyc();
      end
      for (int i = 0; i < 4; i++) drv(i, 0, 0, 0, 0);
      settle();
      chk("t2_tail", 32'(bus.out_valid), 1);
      cyc();

      // backpressure
      drv(1, 1, 3, 1, 1);
      push(8'h08, 1, 1);
      settle();
      chk("t3_ready", 32'(bus.req_ready), 32'h2);
      cyc();
      drv(1, 1, 6, 1, 1);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t3_stall_ready", 32'(bus.req_ready), 0);
         chk("t3_hold_valid",  32'(bus.out_valid), 1);
         chk("t3_hold_onehot", 32'(bus.out_onehot), 32'h08);
         chk("t3_hold_id",     32'(bus.out_id), 1);
         cyc();
      end
      bus.out_ready = 1'b1;
      push(8'h40, 1, 1);
      settle();
      chk("t3_resume", 32'(bus.req_ready), 32'h2);
      cyc();
      drv(1, 0, 0, 0, 0);
      settle();
      chk("t3_nobubble", 32'(bus.out_valid), 1);
      chk("t3_overwrite", 32'(bus.out_onehot), 32'h40);
      cyc();

      // burst from req 0 blocks req 3
      drv(0, 1, 0, 1, 0);
      push(8'h01, 0, 0);
      settle();
      chk("t4_first", 32'(bus.req_ready), 32'h1);
      chk("t4_idle_busy", 32'(busy), 0);
      cyc();
      drv(0, 1, 2, 1, 0);
      drv(3, 1, 7, 1, 1);
      push(8'h04, 0, 0);
      settle();
      chk("t4_block", 32'(bus.req_ready), 32'h1);
      chk("t4_busy", 32'(busy), 1);
      cyc();
      drv(0, 1, 4, 1, 1);
      push(8'h10, 0, 1);
      settle();
      chk("t4_block2", 32'(bus.req_ready), 32'h1);
      chk("t4_busy2", 32'(busy), 1);
      cyc();
      drv(0, 0, 0, 0, 0);
      push(8'h80, 3, 1);
      settle();
      chk("t4_handoff", 32'(bus.req_ready), 32'h8);
      chk("t4_release", 32'(busy), 0);
      cyc();
      drv(3, 0, 0, 0, 0);
      cyc();

      // idle owner timeout
      drv(1, 1, 1, 1, 0);
      push(8'h02, 1, 0);
      settle();
      chk("t5_first", 32'(bus.req_ready), 32'h2);
      cyc();
      drv(1, 0, 0, 0, 0);
      drv(2, 1, 2, 1, 1);
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("t5_busy",    32'(busy), 1);
         chk("t5_no_tout", 32'(lock_timeout), 0);
         chk("t5_blocked", 32'(bus.req_ready), 32'h2);
         cyc();
      end
      settle();
      chk("t5_tout", 32'(lock_timeout), 1);
      chk("t5_free", 32'(busy), 0);
      chk("t5_next", 32'(bus.req_ready), 32'h4);
      push(8'h04, 2, 1);
      cyc();
      drv(2, 0, 0, 0, 0);
      settle();
      chk("t5_pulse", 32'(lock_timeout), 0);
      cyc();

      // async reset mid-burst
      bus.out_ready = 1'b0;
      drv(3, 1, 3, 1, 0);
      settle();
      chk("t6_grant", 32'(bus.req_ready), 32'h8);
      cyc();
      settle();
      chk("t6_pre_valid", 32'(bus.out_valid), 1);
      chk("t6_pre_busy",  32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid",  32'(bus.out_valid), 0);
      chk("t6_async_onehot", 32'(bus.out_onehot), 0);
      chk("t6_async_busy",   32'(busy), 0);
      chk("t6_async_ready",  32'(bus.req_ready), 0);
      for (int i = 0; i < 4; i++) drv(i, 0, 0, 0, 0);
      bus.out_ready = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) drv(i, 1, 3'(2*i+1), 1, 1);
      push(8'h02, 0, 1);
      settle();
      chk("t6_ptr0", 32'(bus.req_ready), 32'h1);
      chk("t6_arb",  32'(busy), 0);
      cyc();
      for (int i = 0; i < 4; i++) drv(i, 0, 0, 0, 0);
      cyc();
      cyc();
      chk("drain", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
